// File: rtl/muldiv_sequencer_if.sv
// Control bundle between the main controller,
// the mul/div units and the HI/LO sequencer.
interface muldiv_sequencer_if;
    logic op_mult;
    logic op_div;
    logic divisor_zero;
    logic mult_done;
    logic div_done;
    logic mult_start;
    logic div_start;
    logic high_load;
    logic low_load;
    logic mux_high_selector;
    logic mux_low_selector;
    logic busy;
    logic done;
    logic div_zero_exc;
    logic timeout_err;

    modport master (
        output op_mult,
        output op_div,
        output divisor_zero,
        output mult_done,
        output div_done,
        input  mult_start,
        input  div_start,
        input  high_load,
        input  low_load,
        input  mux_high_selector,
        input  mux_low_selector,
        input  busy,
        input  done,
        input  div_zero_exc,
        input  timeout_err
    );

    modport slave (
        input  op_mult,
        input  op_div,
        input  divisor_zero,
        input  mult_done,
        input  div_done,
        output mult_start,
        output div_start,
        output high_load,
        output low_load,
        output mux_high_selector,
        output mux_low_selector,
        output busy,
        output done,
        output div_zero_exc,
        output timeout_err
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/DIV sequencer: starts a unit, waits for it
// with a watchdog, then loads HI/LO and reports.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input logic                clk,
    input logic                reset,
    muldiv_sequencer_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST =
        CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        FIN,
        EXC,
        ERR
    } state_t;

    state_t        state;
    logic          sel;
    logic [CW-1:0] cnt;
    logic          unit_done;

    // only the done of the unit we started counts
    assign unit_done = sel ? bus.div_done
                           : bus.mult_done;

    // sequencing FSM, active-unit select, watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.op_mult) begin
                        sel   <= 1'b0;
                        state <= ISSUE;
                    end else if (bus.op_div) begin
                        if (bus.divisor_zero) begin
                            state <= EXC;
                        end else begin
                            sel   <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (unit_done) begin
                        state <= WRITE;
                    end else if (cnt == LAST) begin
                        state <= ERR;
                    end
                end
                WRITE:   state <= FIN;
                FIN:     state <= IDLE;
                EXC:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mult_start = (state == ISSUE) && !sel;
    assign bus.div_start  = (state == ISSUE) && sel;
    assign bus.high_load  = (state == WRITE);
    assign bus.low_load   = (state == WRITE);
    assign bus.mux_high_selector = sel;
    assign bus.mux_low_selector  = sel;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == FIN);
    assign bus.div_zero_exc = (state == EXC);
    assign bus.timeout_err  = (state == ERR);

endmodule
